// File: rtl/bcd_scan_decoder.sv
// Multiplexed 7-segment driver for a packed 8421 BCD word: latches the word, scans one digit per
// SCAN_DIV cycles and drives the digit enable, segments and one-hot value of the scanned digit.
module bcd_scan_decoder #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic [9:0]            onehot,
  output logic                  err
);

  localparam int unsigned PcW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PcW-1:0]  PcLast  = PcW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [4*DIGITS-1:0] shd_q;
  logic                err_q;
  logic [PcW-1:0]      pc_q;
  logic [IdxW-1:0]     idx_q;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic [9:0]          onehot_q;

  logic                err_d;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          seg_d;
  logic [9:0]          onehot_d;
  logic [3:0]          digit;
  logic [DIGITS-1:0]   lz;
  logic                nz_above;
  logic                blank;
  logic                wrap;

  assign wrap = (pc_q == PcLast);

  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      err_d = err_d | (bcd_in[4*i +: 4] > 4'd9);
    end
  end

  // lz[i] is set when digit i and every digit above it are zero
  always_comb begin
    nz_above = 1'b0;
    lz       = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nz_above = nz_above | (shd_q[4*i +: 4] != 4'd0);
      lz[i]    = ~nz_above;
    end
  end

  always_comb begin
    digit = 4'd0;
    an_d  = '0;
    blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        digit   = shd_q[4*i +: 4];
        an_d[i] = 1'b1;
        blank   = blank_lz && (i != 0) && lz[i];
      end
    end
  end

  always_comb begin
    unique case (digit)
      4'd0:    seg_d = 7'h3f;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5b;
      4'd3:    seg_d = 7'h4f;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6d;
      4'd6:    seg_d = 7'h7d;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7f;
      4'd9:    seg_d = 7'h6f;
      default: seg_d = 7'h40;
    endcase
    onehot_d = (digit <= 4'd9) ? (10'd1 << digit) : 10'd0;
    if (blank) begin
      seg_d    = 7'h00;
      onehot_d = 10'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_q    <= '0;
      err_q    <= 1'b0;
      pc_q     <= '0;
      idx_q    <= '0;
      an_q     <= '0;
      seg_q    <= '0;
      onehot_q <= '0;
    end else begin
      if (load) begin
        shd_q <= bcd_in;
        err_q <= err_d;
      end
      if (wrap) begin
        pc_q  <= '0;
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        pc_q  <= pc_q + 1'b1;
      end
      an_q     <= an_d;
      seg_q    <= seg_d;
      onehot_q <= onehot_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign onehot = onehot_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed bench for bcd_scan_decoder: one instance scanning every 3 cycles, one every cycle,
// sharing all inputs.
module tb_bcd_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;

  logic [3:0]  an3, an1;
  logic [6:0]  seg3, seg1;
  logic [9:0]  oh3, oh1;
  logic        err3, err1;

  int passed;
  int total;

  bcd_scan_decoder #(.DIGITS(4), .SCAN_DIV(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .an       (an3),
    .seg      (seg3),
    .onehot   (oh3),
    .err      (err3)
  );

  bcd_scan_decoder #(.DIGITS(4), .SCAN_DIV(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .an       (an1),
    .seg      (seg1),
    .onehot   (oh1),
    .err      (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset deasserted with no edge taken yet; the next step() is edge 1 after release.
  task automatic reset_all();
    rst_n = 1'b0;
    load  = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bcd_in   = 16'h0000;
    blank_lz = 1'b0;
    reset_all();
    total++;
    if ({an3, seg3, oh3, err3} !== 22'd0) $display("FAIL reset3 got %h want 0", {an3, seg3, oh3, err3});
    else passed++;
    total++;
    if ({an1, seg1, oh1, err1} !== 22'd0) $display("FAIL reset1 got %h want 0", {an1, seg1, oh1, err1});
    else passed++;
    step();
    total++;
    if ({an3, seg3, oh3} !== {4'b0001, 7'h3f, 10'h001})
      $display("FAIL release got an=%b seg=%h oh=%h want an=0001 seg=3f oh=001", an3, seg3, oh3);
    else passed++;
  endtask

  // Continues from edge 1 after release; each digit dwells 3 cycles.
  task automatic test_scan();
    logic [3:0] exp_an;
    for (int e = 2; e <= 24; e++) begin
      step();
      exp_an = 4'b0001 << (((e - 1) / 3) % 4);
      total++;
      if ({an3, seg3, oh3, err3} !== {exp_an, 7'h3f, 10'h001, 1'b0})
        $display("FAIL scan e=%0d got an=%b seg=%h oh=%h err=%b want an=%b seg=3f oh=001 err=0",
                 e, an3, seg3, oh3, err3, exp_an);
      else passed++;
    end
  endtask

  task automatic test_load();
    logic [20:0] exp [4];
    exp[0] = {4'b0001, 7'h7d, 10'h040};
    exp[1] = {4'b0010, 7'h07, 10'h080};
    exp[2] = {4'b0100, 7'h7f, 10'h100};
    exp[3] = {4'b1000, 7'h6f, 10'h200};
    reset_all();
    repeat (3) step();
    load   = 1'b1;
    bcd_in = 16'h9876;
    step();
    load = 1'b0;
    total++;
    if (err1 !== 1'b0) $display("FAIL load_err got %b want 0", err1);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({an1, seg1, oh1} !== exp[k]) $display("FAIL load d%0d got %h want %h", k, {an1, seg1, oh1}, exp[k]);
      else passed++;
    end
  endtask

  task automatic test_invalid();
    logic [20:0] exp [4];
    exp[0] = {4'b0001, 7'h6d, 10'h020};
    exp[1] = {4'b0010, 7'h3f, 10'h001};
    exp[2] = {4'b0100, 7'h40, 10'h000};
    exp[3] = {4'b1000, 7'h3f, 10'h001};
    reset_all();
    repeat (3) step();
    load   = 1'b1;
    bcd_in = 16'h0f05;
    step();
    load = 1'b0;
    total++;
    if (err1 !== 1'b1) $display("FAIL invalid_err got %b want 1", err1);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({an1, seg1, oh1} !== exp[k]) $display("FAIL invalid d%0d got %h want %h", k, {an1, seg1, oh1}, exp[k]);
      else passed++;
    end
    load   = 1'b1;
    bcd_in = 16'h0005;
    step();
    load = 1'b0;
    total++;
    if (err1 !== 1'b0) $display("FAIL invalid_clear got %b want 0", err1);
    else passed++;
  endtask

  task automatic test_blank(input logic [15:0] word, input logic [20:0] e0, input logic [20:0] e1,
                            input logic [20:0] e2, input logic [20:0] e3);
    logic [20:0] exp [4];
    exp[0] = e0;
    exp[1] = e1;
    exp[2] = e2;
    exp[3] = e3;
    blank_lz = 1'b1;
    reset_all();
    repeat (3) step();
    load   = 1'b1;
    bcd_in = word;
    step();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({an1, seg1, oh1} !== exp[k])
        $display("FAIL blank %h d%0d got %h want %h", word, k, {an1, seg1, oh1}, exp[k]);
      else passed++;
    end
  endtask

  task automatic test_blank_toggle();
    blank_lz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({an1, seg1, oh1} !== {4'b0001 << k, 7'h3f, 10'h001})
        $display("FAIL unblank d%0d got an=%b seg=%h oh=%h want seg=3f oh=001", k, an1, seg1, oh1);
      else passed++;
    end
  endtask

  // Load held high: each edge loads a word whose only nonzero digit is the one read next edge.
  task automatic test_back_to_back();
    logic [15:0] words [4];
    logic [6:0]  segs  [4];
    words[0] = 16'h0010; segs[0] = 7'h06;
    words[1] = 16'h0200; segs[1] = 7'h5b;
    words[2] = 16'h3000; segs[2] = 7'h4f;
    words[3] = 16'h0004; segs[3] = 7'h66;
    blank_lz = 1'b0;
    reset_all();
    load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bcd_in = words[k];
      step();
      if (k > 0) begin
        total++;
        if (seg1 !== segs[k-1]) $display("FAIL b2b k=%0d got %h want %h", k, seg1, segs[k-1]);
        else passed++;
      end
    end
    bcd_in = 16'h00b0;
    step();
    total++;
    if ({seg1, err1} !== {segs[3], 1'b1}) $display("FAIL b2b_err got %h/%b want %h/1", seg1, err1, segs[3]);
    else passed++;
    bcd_in = 16'h0000;
    step();
    load = 1'b0;
    total++;
    if (err1 !== 1'b0) $display("FAIL b2b_clr got %b want 0", err1);
    else passed++;
  endtask

  task automatic test_mid_reset();
    blank_lz = 1'b0;
    reset_all();
    load   = 1'b1;
    bcd_in = 16'h1234;
    step();
    load = 1'b0;
    repeat (6) step();
    total++;
    if ({an3, seg3, oh3} !== {4'b0100, 7'h5b, 10'h004})
      $display("FAIL pre_reset got an=%b seg=%h oh=%h want an=0100 seg=5b oh=004", an3, seg3, oh3);
    else passed++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if ({an3, seg3, oh3, err3} !== 22'd0) $display("FAIL mid_reset got %h want 0", {an3, seg3, oh3, err3});
    else passed++;
    for (int j = 0; j < 12; j++) begin
      step();
      total++;
      if ({an3, seg3, oh3} !== {4'b0001 << (j / 3), 7'h3f, 10'h001})
        $display("FAIL restart j=%0d got an=%b seg=%h oh=%h want an=%b seg=3f oh=001",
                 j, an3, seg3, oh3, 4'b0001 << (j / 3));
      else passed++;
    end
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    bcd_in   = 16'h0000;
    blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_load();
    test_invalid();
    test_blank(16'h0040, {4'b0001, 7'h3f, 10'h001}, {4'b0010, 7'h66, 10'h010},
               {4'b0100, 7'h00, 10'h000}, {4'b1000, 7'h00, 10'h000});
    test_blank(16'h0a00, {4'b0001, 7'h3f, 10'h001}, {4'b0010, 7'h3f, 10'h001},
               {4'b0100, 7'h40, 10'h000}, {4'b1000, 7'h00, 10'h000});
    test_blank(16'h0000, {4'b0001, 7'h3f, 10'h001}, {4'b0010, 7'h00, 10'h000},
               {4'b0100, 7'h00, 10'h000}, {4'b1000, 7'h00, 10'h000});
    test_blank_toggle();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_scan_decoder.md
# bcd_scan_decoder

Inverse companion of the one-hot-to-8421 encoder: latches a multi-digit packed 8421 BCD word and time-multiplexes it onto a common 7-segment display. For the digit currently being scanned, it drives the digit enable, the segment pattern and the 10-line one-hot decode. It sits between the BCD-producing datapath (encoders, counters) and the board's display pins. Invalid codes, including the encoder's 4'b1111 "no valid input" code, are shown as a dash and flagged.

## Interface
- DIGITS, 4: number of BCD digits (1..8).
- SCAN_DIV, 1000: clock cycles each digit is displayed (>=1).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load  in  1  when 1 at a rising edge, bcd_in is captured into the shadow register.
- bcd_in  in  4*DIGITS  packed digits; digit i = bcd_in[4i+3:4i]; digit 0 is least significant.
- blank_lz  in  1  1 = blank leading zeros.
- an  out  DIGITS  one-hot digit enable, active-high; an[i] selects digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- onehot  out  10  one-hot decode of the scanned digit; bit v set for value v.
- err  out  1  1 while any shadow digit is >9.

## Operation
- Shadow register `shd`:
  - Reset to 0.
  - On load=1, shd <= bcd_in.
  - err is registered and updates at the same edge from bcd_in: err = OR over digits of (nibble > 9).
- Prescaler `pc` (width clog2(SCAN_DIV), min 1):
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - Digit index `idx` advances on the wrap: idx goes DIGITS-1 -> 0.
  - SCAN_DIV=1 advances idx every cycle.
- Decode of nibble d = shd digit idx:
  - 0..9 → seg = 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); onehot = 1<<d.
  - 10..15 → seg = 40 (dash); onehot = 0.
- Leading-zero blanking, when blank_lz=1:
  - Digit i>0 is blank if it and every higher digit equal 0.
  - Blank means seg = 00 and onehot = 0; an is still driven.
  - Digit 0 is never blanked.
  - A digit >9 is never blank, and any nonzero digit (valid or invalid) stops blanking below it.
- Output register: at each edge, an/seg/onehot <= decode(shd, idx), using the values of shd and idx before that edge.

## Timing
- Reset values (rst_n=0 at an edge): shd=0, err=0, pc=0, idx=0, an=0, seg=0, onehot=0.
- First edge with rst_n=1: an=0001, seg=3F, onehot=0000000001.
- Load latency:
  - Load sampled at edge k → shd and err valid after edge k.
  - an/seg/onehot reflect the new data from edge k+1.
- Scan latency:
  - idx changes at edge k → an changes at edge k+1.
  - Each digit is shown for exactly SCAN_DIV cycles; full frame = DIGITS*SCAN_DIV cycles.
- Simultaneous load and idx advance at the same edge: both take effect; the output at the next edge uses the new idx and the new shd.
- Load held high: shd tracks bcd_in every cycle.
- blank_lz is combinational into decode, so a change affects outputs at the next edge.
- rst_n low mid-frame, at any pc/idx: all state returns to reset values at that edge. The scan restarts at digit 0 with a full SCAN_DIV dwell.
- an is never all-zero after reset release; exactly one bit is set.

## Test plan
- Reset then run, DIGITS=4, SCAN_DIV=3, no load:
  - Edge after release: an=0001, seg=3F, onehot=001.
  - an sequence 0001×3, 0010×3, 0100×3, 1000×3, then repeats.
  - err=0.
- Load bcd_in=16'h9876 with blank_lz=0, SCAN_DIV=1:
  - From the next edge, consecutive (an, seg, onehot) = (0001,7D,040), (0010,07,080), (0100,7F,100), (1000,6F,200).
- Load 16'h0F05 (digit 2 = 4'hF, the encoder error code):
  - err=1 one edge after load.
  - Digit 2 shows seg=40, onehot=000.
  - Reloading 16'h0005 clears err at the next edge.
- Load 16'h0040 with blank_lz=1: digit 3 → seg=00; digit 2 → seg=00; digit 1 → seg=66; digit 0 → seg=3F.
- Load 16'h0000 with blank_lz=1: only digit 0 lit (seg=3F). Toggling blank_lz=0 restores 3F on all digits from the next edge.
- Assert rst_n=0 for one cycle while idx=2, pc=1, shd=16'h1234:
  - Next edge: an=0, seg=0, err=0.
  - Then an=0001, seg=3F held for SCAN_DIV cycles.
  - shd reads 0.
